// File: rtl/suprloco_rom_loader.sv
// ioctl download sink: packs bytes into 16-bit words, queues them and writes them out over req/ack.
// Optional running byte checksum output when SUPRLOCO_LOADER_CHECKSUM_EN is defined.
module suprloco_rom_loader #(
   parameter int          FIFO_AW     = 3,
   parameter int          WAIT_MARGIN = 2,
   parameter logic [15:0] ROM_INDEX   = 16'h0000
) (
   input  logic        i_EMU_MCLK,
   input  logic        i_EMU_RST_n,
   input  logic [15:0] ioctl_index,
   input  logic        ioctl_download,
   input  logic [26:0] ioctl_addr,
   input  logic [7:0]  ioctl_data,
   input  logic        ioctl_wr,
   output logic        ioctl_wait,
   output logic [25:0] o_MEM_ADDR,
   output logic [15:0] o_MEM_DATA,
   output logic [1:0]  o_MEM_BE,
   output logic        o_MEM_REQ,
   input  logic        i_MEM_ACK,
   output logic        o_BUSY,
   output logic        o_DONE,
   output logic        o_OVERFLOW
`ifdef SUPRLOCO_LOADER_CHECKSUM_EN
   ,
   output logic [15:0] o_CHECKSUM
`endif
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0]   DEPTH_W  = (FIFO_AW+1)'(DEPTH);
   localparam logic [FIFO_AW:0]   MARGIN_W = (FIFO_AW+1)'(WAIT_MARGIN);
   localparam logic [FIFO_AW:0]   CNT_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
   localparam logic [FIFO_AW:0]   CNT_ZERO = {(FIFO_AW+1){1'b0}};
   localparam logic [FIFO_AW-1:0] PTR_ONE  = {{(FIFO_AW-1){1'b0}}, 1'b1};

   typedef enum logic {ST_IDLE = 1'b0, ST_REQ = 1'b1} state_t;

   state_t state_r, state_n;
   logic dl_q_r, dl_rise_s, dl_fall_s, accept_s;
   logic [25:0] waddr_s;
   logic [15:0] byte_data_s, merge_data_s;
   logic [1:0]  byte_be_s, merge_be_s;
   logic        pend_valid_r, pend_valid_n;
   logic [25:0] pend_addr_r, pend_addr_n;
   logic [15:0] pend_data_r, pend_data_n;
   logic [1:0]  pend_be_r, pend_be_n;
   logic        push_s, do_push_s, pop_s, load_s, full_s;
   logic [43:0] push_entry_s;
   logic [43:0] fifo_mem_r [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_r, rd_ptr_r;
   logic [FIFO_AW:0]   count_r, count_n, free_n_s;
   logic overflow_r, wait_r, done_r, armed_r, busy_r, req_r;
   logic [25:0] mem_addr_r;
   logic [15:0] mem_data_r;
   logic [1:0]  mem_be_r;

   assign dl_rise_s    = ioctl_download & ~dl_q_r;
   assign dl_fall_s    = ~ioctl_download & dl_q_r;
   assign accept_s     = ioctl_wr & ioctl_download & (ioctl_index == ROM_INDEX);
   assign waddr_s      = ioctl_addr[26:1];
   assign byte_data_s  = ioctl_addr[0] ? {ioctl_data, 8'h00} : {8'h00, ioctl_data};
   assign byte_be_s    = ioctl_addr[0] ? 2'b10 : 2'b01;
   assign merge_data_s = ioctl_addr[0] ? {ioctl_data, pend_data_r[7:0]} : {pend_data_r[15:8], ioctl_data};
   assign merge_be_s   = pend_be_r | byte_be_s;
   assign full_s       = (count_r == DEPTH_W);
   assign do_push_s    = push_s & ~full_s;
   assign free_n_s     = DEPTH_W - count_n;

   // Byte packing: merge into the pending word, push completed or displaced words, flush at end.
   always_comb begin
      pend_valid_n = pend_valid_r;
      pend_addr_n  = pend_addr_r;
      pend_data_n  = pend_data_r;
      pend_be_n    = pend_be_r;
      push_s       = 1'b0;
      push_entry_s = {pend_addr_r, pend_data_r, pend_be_r};
      if (accept_s) begin
         if (pend_valid_r && (pend_addr_r == waddr_s)) begin
            if (merge_be_s == 2'b11) begin
               push_s       = 1'b1;
               push_entry_s = {waddr_s, merge_data_s, 2'b11};
               pend_valid_n = 1'b0;
            end else begin
               pend_data_n = merge_data_s;
               pend_be_n   = merge_be_s;
            end
         end else begin
            push_s       = pend_valid_r;
            pend_valid_n = 1'b1;
            pend_addr_n  = waddr_s;
            pend_data_n  = byte_data_s;
            pend_be_n    = byte_be_s;
         end
      end else if (dl_fall_s && pend_valid_r) begin
         push_s       = 1'b1;
         pend_valid_n = 1'b0;
      end else begin
         push_s = 1'b0;
      end
   end

   // Write-port FSM next state: issue from FIFO head, retire on ack.
   always_comb begin
      state_n = state_r;
      load_s  = 1'b0;
      pop_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (count_r != CNT_ZERO) begin
               load_s  = 1'b1;
               state_n = ST_REQ;
            end else begin
               state_n = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (i_MEM_ACK) begin
               pop_s   = 1'b1;
               state_n = ST_IDLE;
            end else begin
               state_n = ST_REQ;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // FIFO occupancy after this cycle's push/pop.
   always_comb begin
      case ({do_push_s, pop_s})
         2'b10:   count_n = count_r + CNT_ONE;
         2'b01:   count_n = count_r - CNT_ONE;
         default: count_n = count_r;
      endcase
   end

   // FIFO storage holds data only; validity is tracked by the pointers.
   always_ff @(posedge i_EMU_MCLK) begin
      if (do_push_s) begin
         fifo_mem_r[wr_ptr_r] <= push_entry_s;
      end else begin
         fifo_mem_r[wr_ptr_r] <= fifo_mem_r[wr_ptr_r];
      end
   end

   // Pending word, FIFO pointers, FSM state and status registers.
   always_ff @(posedge i_EMU_MCLK or negedge i_EMU_RST_n) begin
      if (!i_EMU_RST_n) begin
         dl_q_r       <= 1'b0;
         pend_valid_r <= 1'b0;
         pend_addr_r  <= 26'd0;
         pend_data_r  <= 16'h0000;
         pend_be_r    <= 2'b00;
         wr_ptr_r     <= {FIFO_AW{1'b0}};
         rd_ptr_r     <= {FIFO_AW{1'b0}};
         count_r      <= CNT_ZERO;
         state_r      <= ST_IDLE;
         overflow_r   <= 1'b0;
         wait_r       <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         dl_q_r       <= ioctl_download;
         pend_valid_r <= pend_valid_n;
         pend_addr_r  <= pend_addr_n;
         pend_data_r  <= pend_data_n;
         pend_be_r    <= pend_be_n;
         wr_ptr_r     <= do_push_s ? wr_ptr_r + PTR_ONE : wr_ptr_r;
         rd_ptr_r     <= pop_s ? rd_ptr_r + PTR_ONE : rd_ptr_r;
         count_r      <= count_n;
         state_r      <= state_n;
         wait_r       <= (free_n_s <= MARGIN_W);
         busy_r       <= pend_valid_n | (count_n != CNT_ZERO) | (state_n == ST_REQ);
         if (dl_rise_s) begin
            overflow_r <= 1'b0;
         end else if (push_s && full_s) begin
            overflow_r <= 1'b1;
         end else begin
            overflow_r <= overflow_r;
         end
      end
   end

   // Memory write port; outputs stay frozen while a request is outstanding.
   always_ff @(posedge i_EMU_MCLK or negedge i_EMU_RST_n) begin
      if (!i_EMU_RST_n) begin
         req_r      <= 1'b0;
         mem_addr_r <= 26'd0;
         mem_data_r <= 16'h0000;
         mem_be_r   <= 2'b00;
      end else if (load_s) begin
         req_r <= 1'b1;
         {mem_addr_r, mem_data_r, mem_be_r} <= fifo_mem_r[rd_ptr_r];
      end else if (pop_s) begin
         req_r <= 1'b0;
      end else begin
         req_r <= req_r;
      end
   end

   // Done is armed only by a download aimed at this loader and fires once everything drained.
   always_ff @(posedge i_EMU_MCLK or negedge i_EMU_RST_n) begin
      if (!i_EMU_RST_n) begin
         done_r  <= 1'b0;
         armed_r <= 1'b0;
      end else if (dl_rise_s) begin
         done_r  <= 1'b0;
         armed_r <= (ioctl_index == ROM_INDEX);
      end else if (armed_r && !ioctl_download && !dl_q_r && !pend_valid_r &&
                   (count_r == CNT_ZERO) && (state_r == ST_IDLE)) begin
         done_r  <= 1'b1;
         armed_r <= 1'b0;
      end else begin
         done_r  <= done_r;
         armed_r <= armed_r;
      end
   end

`ifdef SUPRLOCO_LOADER_CHECKSUM_EN
   logic [15:0] checksum_r;

   // Running byte sum, restarted by each download.
   always_ff @(posedge i_EMU_MCLK or negedge i_EMU_RST_n) begin
      if (!i_EMU_RST_n) begin
         checksum_r <= 16'h0000;
      end else if (dl_rise_s) begin
         checksum_r <= accept_s ? {8'h00, ioctl_data} : 16'h0000;
      end else if (accept_s) begin
         checksum_r <= checksum_r + {8'h00, ioctl_data};
      end else begin
         checksum_r <= checksum_r;
      end
   end

   assign o_CHECKSUM = checksum_r;
`endif

   assign ioctl_wait = wait_r;
   assign o_MEM_ADDR = mem_addr_r;
   assign o_MEM_DATA = mem_data_r;
   assign o_MEM_BE   = mem_be_r;
   assign o_MEM_REQ  = req_r;
   assign o_BUSY     = busy_r;
   assign o_DONE     = done_r;
   assign o_OVERFLOW = overflow_r;

endmodule

// File: tb/tb_suprloco_rom_loader.sv
// Self-checking bench for suprloco_rom_loader: directed and randomized downloads against a word-packing model.
module tb_suprloco_rom_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [15:0] ioctl_index;
   logic        ioctl_download;
   logic [26:0] ioctl_addr;
   logic [7:0]  ioctl_data;
   logic        ioctl_wr;
   logic        ioctl_wait;
   logic [25:0] mem_addr;
   logic [15:0] mem_data;
   logic [1:0]  mem_be;
   logic        mem_req;
   logic        mem_ack;
   logic        busy, done, overflow;
`ifdef SUPRLOCO_LOADER_CHECKSUM_EN
   logic [15:0] checksum;
`endif

   int n_checks = 0;
   int n_pass   = 0;
   bit ack_en   = 1'b0;
   bit ack_rand = 1'b0;
   logic [43:0] got_q[$];
   logic [43:0] exp_q[$];
   logic [26:0] ba_q[$];
   logic [7:0]  bd_q[$];

   suprloco_rom_loader dut (
      .i_EMU_MCLK    (clk),
      .i_EMU_RST_n   (rst_n),
      .ioctl_index   (ioctl_index),
      .ioctl_download(ioctl_download),
      .ioctl_addr    (ioctl_addr),
      .ioctl_data    (ioctl_data),
      .ioctl_wr      (ioctl_wr),
      .ioctl_wait    (ioctl_wait),
      .o_MEM_ADDR    (mem_addr),
      .o_MEM_DATA    (mem_data),
      .o_MEM_BE      (mem_be),
      .o_MEM_REQ     (mem_req),
      .i_MEM_ACK     (mem_ack),
      .o_BUSY        (busy),
      .o_DONE        (done),
      .o_OVERFLOW    (overflow)
`ifdef SUPRLOCO_LOADER_CHECKSUM_EN
      ,
      .o_CHECKSUM    (checksum)
`endif
   );

   // Memory side: acknowledge outstanding requests, optionally with random delay.
   always @(negedge clk) begin
      if (ack_en && mem_req && !mem_ack && (!ack_rand || $urandom_range(0, 2) != 0))
         mem_ack = 1'b1;
      else
         mem_ack = 1'b0;
   end

   // Capture every accepted memory write.
   always @(posedge clk) begin
      if (rst_n && mem_req && mem_ack) got_q.push_back({mem_addr, mem_data, mem_be});
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Reference: bytes in arrival order -> word writes, emitted when complete, displaced, or at end.
   function automatic void build_expected();
      bit v = 1'b0;
      logic [25:0] wa = 26'd0;
      logic [15:0] wd = 16'h0000;
      logic [1:0]  wb = 2'b00;
      exp_q.delete();
      foreach (ba_q[i]) begin
         if (v && ba_q[i][26:1] != wa) begin
            exp_q.push_back({wa, wd, wb});
            v = 1'b0;
         end
         if (!v) begin
            v = 1'b1; wa = ba_q[i][26:1]; wd = 16'h0000; wb = 2'b00;
         end
         if (ba_q[i][0]) begin wd[15:8] = bd_q[i]; wb[1] = 1'b1; end
         else            begin wd[7:0]  = bd_q[i]; wb[0] = 1'b1; end
         if (wb == 2'b11) begin
            exp_q.push_back({wa, wd, wb});
            v = 1'b0;
         end
      end
      if (v) exp_q.push_back({wa, wd, wb});
   endfunction

   function automatic logic [15:0] model_sum();
      logic [15:0] s = 16'h0000;
      foreach (bd_q[i]) s = s + {8'h00, bd_q[i]};
      return s;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic start_dl(input logic [15:0] idx);
      @(negedge clk);
      ioctl_index = idx;
      ioctl_download = 1'b1;
      ba_q.delete(); bd_q.delete(); got_q.delete();
      @(negedge clk);
   endtask

   task automatic send_byte(input logic [26:0] a, input logic [7:0] d, input bit honor);
      int n = 0;
      while (honor && ioctl_wait && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) begin
         n_checks++;
         $display("FAIL wait_timeout: ioctl_wait stuck high=%0b, required low", ioctl_wait);
      end
      ioctl_addr = a; ioctl_data = d; ioctl_wr = 1'b1;
      if (ioctl_index == 16'h0000) begin
         ba_q.push_back(a);
         bd_q.push_back(d);
      end
      @(negedge clk);
      ioctl_wr = 1'b0;
   endtask

   task automatic end_dl_wait(output bit ok);
      ioctl_download = 1'b0;
      for (int n = 0; n < 1000 && !done; n++) @(negedge clk);
      ok = done;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; ioctl_index = 16'h0000; ioctl_download = 1'b0;
      ioctl_addr = 27'd0; ioctl_data = 8'h00; ioctl_wr = 1'b0; mem_ack = 1'b0;
      tick(3);
      n_checks++;
      if ({mem_req, ioctl_wait, busy, done, overflow} !== 5'b00000)
         $display("FAIL reset_flags: got %b, required 00000", {mem_req, ioctl_wait, busy, done, overflow});
      else n_pass++;
      n_checks++;
      if ({mem_addr, mem_data, mem_be} !== 44'd0)
         $display("FAIL reset_mem: got %h, required 0", {mem_addr, mem_data, mem_be});
      else n_pass++;
      rst_n = 1'b1;
      tick(3);
      n_checks++;
      if (done !== 1'b0) $display("FAIL reset_done_idle: got %b, required 0", done);
      else n_pass++;
   endtask

   task automatic test_basic();
      bit ok;
      logic [43:0] e [2];
      e[0] = {26'd0, 16'h2211, 2'b11};
      e[1] = {26'd1, 16'h4433, 2'b11};
      ack_en = 1'b1; ack_rand = 1'b0;
      start_dl(16'h0000);
      send_byte(27'd0, 8'h11, 1'b1);
      send_byte(27'd1, 8'h22, 1'b1);
      send_byte(27'd2, 8'h33, 1'b1);
      send_byte(27'd3, 8'h44, 1'b1);
      n_checks++;
      if (done !== 1'b0) $display("FAIL basic_done_early: got %b, required 0", done);
      else n_pass++;
      end_dl_wait(ok);
      n_checks++;
      if (ok !== 1'b1) $display("FAIL basic_done: got %b, required 1", ok);
      else n_pass++;
      n_checks++;
      if (got_q.size() != 2) $display("FAIL basic_count: got %0d writes, required 2", got_q.size());
      else n_pass++;
      for (int i = 0; i < 2 && i < got_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== e[i]) $display("FAIL basic_write%0d: got %h, required %h", i, got_q[i], e[i]);
         else n_pass++;
      end
      n_checks++;
      if (busy !== 1'b0) $display("FAIL basic_busy: got %b, required 0", busy);
      else n_pass++;
`ifdef SUPRLOCO_LOADER_CHECKSUM_EN
      n_checks++;
      if (checksum !== 16'h00AA) $display("FAIL basic_checksum: got %h, required 00aa", checksum);
      else n_pass++;
`endif
   endtask

   task automatic test_single();
      bit ok;
      logic [43:0] e;
      e = {26'd2, 16'hAB00, 2'b10};
      start_dl(16'h0000);
      send_byte(27'd5, 8'hAB, 1'b1);
      end_dl_wait(ok);
      n_checks++;
      if (ok !== 1'b1) $display("FAIL single_done: got %b, required 1", ok);
      else n_pass++;
      n_checks++;
      if (got_q.size() != 1 || got_q[0] !== e)
         $display("FAIL single_write: got %0d writes first %h, required 1 write %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 44'd0, e);
      else n_pass++;
   endtask

   task automatic test_split();
      bit ok;
      logic [7:0] d0, d1;
      logic [43:0] e0, e1;
      d0 = 8'($urandom); d1 = 8'($urandom);
      e0 = {26'd0, 8'h00, d0, 2'b01};
      e1 = {26'd2, 8'h00, d1, 2'b01};
      start_dl(16'h0000);
      send_byte(27'd0, d0, 1'b1);
      send_byte(27'd4, d1, 1'b1);
      tick(5);
      n_checks++;
      if (got_q.size() != 1 || busy !== 1'b1)
         $display("FAIL split_partial_push: got %0d writes busy %b, required 1 write busy 1", got_q.size(), busy);
      else n_pass++;
      end_dl_wait(ok);
      n_checks++;
      if (got_q.size() != 2 || got_q[0] !== e0 || got_q[1] !== e1)
         $display("FAIL split_writes: got %0d writes, required %h then %h", got_q.size(), e0, e1);
      else n_pass++;
   endtask

   task automatic test_random();
      bit ok;
      int a;
      for (int it = 0; it < 4; it++) begin
         ack_rand = 1'b1;
         start_dl(16'h0000);
         a = $urandom_range(0, 7);
         for (int k = 0; k < 32; k++) begin
            send_byte(27'(a), 8'($urandom), 1'b1);
            a += ($urandom_range(0, 7) == 0) ? $urandom_range(2, 6) : 1;
            if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 3));
         end
         end_dl_wait(ok);
         build_expected();
         n_checks++;
         if (ok !== 1'b1 || got_q.size() != exp_q.size())
            $display("FAIL random%0d_count: done %b writes %0d, required done 1 writes %0d", it, ok, got_q.size(), exp_q.size());
         else n_pass++;
         for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL random%0d_write%0d: got %h, required %h", it, i, got_q[i], exp_q[i]);
            else n_pass++;
         end
         n_checks++;
         if (overflow !== 1'b0) $display("FAIL random%0d_overflow: got %b, required 0", it, overflow);
         else n_pass++;
`ifdef SUPRLOCO_LOADER_CHECKSUM_EN
         n_checks++;
         if (checksum !== model_sum()) $display("FAIL random%0d_checksum: got %h, required %h", it, checksum, model_sum());
         else n_pass++;
`endif
      end
      ack_rand = 1'b0;
   endtask

   task automatic test_backpressure();
      bit ok;
      int sent = 0;
      ack_en = 1'b0;
      start_dl(16'h0000);
      while (!ioctl_wait && sent < 40) begin
         send_byte(27'(sent), 8'($urandom), 1'b1);
         sent++;
      end
      n_checks++;
      if (ioctl_wait !== 1'b1 || sent / 2 < 6 || sent / 2 > 7)
         $display("FAIL bp_wait_rise: wait %b after %0d words, required 1 after 6..7", ioctl_wait, sent / 2);
      else n_pass++;
      tick(5);
      n_checks++;
      if (ioctl_wait !== 1'b1 || overflow !== 1'b0 || got_q.size() != 0)
         $display("FAIL bp_stall: wait %b overflow %b writes %0d, required 1 0 0", ioctl_wait, overflow, got_q.size());
      else n_pass++;
      ack_en = 1'b1;
      while (sent < 40) begin
         send_byte(27'(sent), 8'($urandom), 1'b1);
         sent++;
      end
      end_dl_wait(ok);
      build_expected();
      n_checks++;
      if (ok !== 1'b1 || got_q.size() != exp_q.size() || overflow !== 1'b0)
         $display("FAIL bp_drain: done %b writes %0d overflow %b, required 1 %0d 0", ok, got_q.size(), overflow, exp_q.size());
      else n_pass++;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== exp_q[i]) $display("FAIL bp_write%0d: got %h, required %h", i, got_q[i], exp_q[i]);
         else n_pass++;
      end
      n_checks++;
      if (ioctl_wait !== 1'b0) $display("FAIL bp_wait_fall: got %b, required 0", ioctl_wait);
      else n_pass++;
   endtask

   task automatic test_overflow();
      bit ok;
      ack_en = 1'b0;
      start_dl(16'h0000);
      for (int k = 0; k < 18; k++) send_byte(27'(k), 8'($urandom), 1'b0);
      tick(2);
      n_checks++;
      if (overflow !== 1'b1 || got_q.size() != 0)
         $display("FAIL ovf_set: overflow %b writes %0d, required 1 0", overflow, got_q.size());
      else n_pass++;
      ack_en = 1'b1;
      end_dl_wait(ok);
      build_expected();
      n_checks++;
      if (ok !== 1'b1 || got_q.size() != 8 || exp_q.size() != 9)
         $display("FAIL ovf_count: done %b writes %0d, required 1 8", ok, got_q.size());
      else n_pass++;
      for (int i = 0; i < 8 && i < got_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== exp_q[i]) $display("FAIL ovf_write%0d: got %h, required %h", i, got_q[i], exp_q[i]);
         else n_pass++;
      end
      n_checks++;
      if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b, required 1", overflow);
      else n_pass++;
      start_dl(16'h0000);
      n_checks++;
      if (overflow !== 1'b0 || done !== 1'b0)
         $display("FAIL ovf_clear: overflow %b done %b, required 0 0", overflow, done);
      else n_pass++;
      end_dl_wait(ok);
      n_checks++;
      if (ok !== 1'b1 || got_q.size() != 0) $display("FAIL empty_dl: done %b writes %0d, required 1 0", ok, got_q.size());
      else n_pass++;
   endtask

   task automatic test_index();
      bit busy_seen = 1'b0;
      ack_en = 1'b1;
      start_dl(16'h0001);
      for (int k = 0; k < 6; k++) begin
         send_byte(27'(k), 8'($urandom), 1'b1);
         if (busy) busy_seen = 1'b1;
      end
      ioctl_download = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (busy) busy_seen = 1'b1;
      end
      n_checks++;
      if (busy_seen !== 1'b0 || got_q.size() != 0)
         $display("FAIL index_ignored: busy_seen %b writes %0d, required 0 0", busy_seen, got_q.size());
      else n_pass++;
      ioctl_index = 16'h0000;
   endtask

   task automatic test_reset_in_req();
      int n = 0;
      ack_en = 1'b0;
      start_dl(16'h0000);
      send_byte(27'd0, 8'h5A, 1'b1);
      send_byte(27'd1, 8'hA5, 1'b1);
      while (!mem_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (mem_req !== 1'b1) $display("FAIL rst_req_issue: got %b, required 1", mem_req);
      else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({mem_req, busy, ioctl_wait} !== 3'b000)
         $display("FAIL rst_async: req/busy/wait %b, required 000", {mem_req, busy, ioctl_wait});
      else n_pass++;
      @(negedge clk);
      ioctl_download = 1'b0;
      tick(2);
      rst_n = 1'b1;
      ack_en = 1'b1;
      tick(6);
      n_checks++;
      if (mem_req !== 1'b0 || got_q.size() != 0 || busy !== 1'b0)
         $display("FAIL rst_fifo_empty: req %b writes %0d busy %b, required 0 0 0", mem_req, got_q.size(), busy);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_single();
      test_split();
      test_random();
      test_backpressure();
      test_overflow();
      test_index();
      test_reset_in_req();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/suprloco_rom_loader.md
Name: suprloco_rom_loader

Overview:
- Sink for the HPS ioctl download stream; sits directly downstream of the ioctl source and upstream of the game board's ROM/SDRAM memories.
- Packs incoming bytes into 16-bit words with byte enables and buffers them in a small FIFO.
- Issues req/ack memory writes and throttles the source through ioctl_wait.
- Reports busy, done and overflow status to the emulator core.

Parameters:
- FIFO_AW, 3, log2 of FIFO depth in words (depth 8).
- WAIT_MARGIN, 2, ioctl_wait asserts when free entries <= WAIT_MARGIN.
- ROM_INDEX, 16'h0000, ioctl_index value this loader accepts.

Ports:
- i_EMU_MCLK  in  1  system clock; all logic on rising edge.
- i_EMU_RST_n  in  1  asynchronous active-low reset.
- ioctl_index  in  16  download target selector.
- ioctl_download  in  1  high for the whole transfer.
- ioctl_addr  in  27  byte address.
- ioctl_data  in  8  byte data.
- ioctl_wr  in  1  one-cycle byte strobe.
- ioctl_wait  out  1  throttle request to the source.
- o_MEM_ADDR  out  26  word address (ioctl_addr[26:1]).
- o_MEM_DATA  out  16  write data; even byte in [7:0], odd byte in [15:8].
- o_MEM_BE  out  2  byte enables; [0] = even byte, [1] = odd byte.
- o_MEM_REQ  out  1  write request, level.
- i_MEM_ACK  in  1  write accepted.
- o_BUSY  out  1  pending byte, FIFO not empty, or write in flight.
- o_DONE  out  1  transfer finished and fully written.
- o_OVERFLOW  out  1  sticky; a word was dropped.

Behaviour:
- Reset: all outputs 0, FIFO empty, pending register invalid, FSM in IDLE.
- Byte acceptance: a byte is accepted when ioctl_wr & ioctl_download & (ioctl_index == ROM_INDEX). All other strobes are ignored.
- Pending register holds {waddr, data16, be}.
  - Accepted byte to the same waddr as a valid pending entry: merge the byte lane. If be becomes 2'b11, push to FIFO in the same cycle and invalidate pending.
  - Accepted byte with pending invalid: load it as pending.
  - Accepted byte to a different waddr: push the existing pending entry as-is (partial be), then load the new byte as pending.
  - At most one FIFO push per cycle.
- End-of-download flush: on the falling edge of ioctl_download, a valid pending entry is pushed (partial be) on the next cycle.
- FIFO: entries are {waddr, data16, be}.
  - Push when full: entry dropped, o_OVERFLOW set. o_OVERFLOW clears only on reset or the rising edge of ioctl_download.
  - Push and pop in the same cycle: count unchanged.
  - Pointers wrap modulo 2^FIFO_AW.
- ioctl_wait: registered; high when (2^FIFO_AW - count) <= WAIT_MARGIN. One cycle of latency.
  - The margin also covers the source sending one more strobe after wait rises, plus a same-cycle flush.
- Write FSM:
  - IDLE: FIFO not empty -> load o_MEM_* from FIFO head, assert o_MEM_REQ, go to REQ.
  - REQ: hold o_MEM_ADDR/DATA/BE/REQ stable until i_MEM_ACK is sampled high. Then pop the head, drop REQ the next cycle, return to IDLE. A new request may issue the cycle after.
  - Maximum throughput: one word per 2 cycles.
  - i_MEM_ACK outside REQ is ignored.
- o_DONE:
  - Cleared on the rising edge of ioctl_download.
  - Set once download is low, the flush is complete, the FIFO is empty and the FSM is IDLE with no ack pending.
  - Stays set until the next download or reset.
- Reset mid-transfer: everything returns to reset values immediately. A request in flight is abandoned (REQ drops asynchronously).

Optional Feature:
- Macro: SUPRLOCO_LOADER_CHECKSUM_EN.
- Defined: adds output o_CHECKSUM (16 bits).
  - Running modulo-2^16 sum of every accepted byte, zero-extended.
  - Cleared on the rising edge of ioctl_download; valid when o_DONE rises.
- Undefined: no port and no adder; behaviour otherwise identical.

Test Plan:
- Bytes 0x11,0x22,0x33,0x44 at addr 0..3, ack 1 cycle after each req -> writes (waddr 0, 16'h2211, BE 11) then (1, 16'h4433, 11); o_DONE rises once download is low.
- Single byte 0xAB at addr 5, then download low -> one write (waddr 2, 16'hAB00, BE 10); o_DONE=1.
- Bytes at addr 0 then addr 4 -> (0, xx=0x.., BE 01) pushed when the addr-4 byte arrives; then (2, BE 01) on flush.
- i_MEM_ACK held low, source streams continuously -> ioctl_wait high at 6 used entries; no overflow with a compliant source; entries drain in order once ack resumes.
- Source ignoring ioctl_wait with ack low -> the 9th word is dropped, o_OVERFLOW=1; it clears on the next download start.
- ioctl_index=1 strobes -> no writes, o_BUSY stays 0. Reset asserted in REQ -> o_MEM_REQ=0 immediately and FIFO empty.
